// File: rtl/spi_pad_arbiter_if.sv
// Bus bundle between two SPI master peripherals, the pad arbiter and the pad ring.
// slave:  arbiter view (peripheral/pad signals in, grants and pad drives out).
// master: environment view (peripherals and pads).
interface spi_pad_arbiter_if;
  logic [1:0]      req_i;
  logic [1:0]      gnt_o;
  logic [1:0]      spi_clk_i;
  logic [1:0][3:0] spi_csn_i;
  logic [1:0][3:0] spi_oen_i;
  logic [1:0][3:0] spi_sdo_i;
  logic [1:0][3:0] spi_sdi_o;
  logic            pad_clk_o;
  logic [3:0]      pad_csn_o;
  logic [3:0]      pad_oen_o;
  logic [3:0]      pad_sdo_o;
  logic [3:0]      pad_sdi_i;
  logic            busy_o;

  modport slave (
    input  req_i, spi_clk_i, spi_csn_i, spi_oen_i, spi_sdo_i, pad_sdi_i,
    output gnt_o, spi_sdi_o, pad_clk_o, pad_csn_o, pad_oen_o, pad_sdo_o, busy_o
  );

  modport master (
    output req_i, spi_clk_i, spi_csn_i, spi_oen_i, spi_sdo_i, pad_sdi_i,
    input  gnt_o, spi_sdi_o, pad_clk_o, pad_csn_o, pad_oen_o, pad_sdo_o, busy_o
  );
endinterface

// File: rtl/spi_pad_arbiter.sv
// Round-robin arbiter sharing one set of SPI master pads between two peripherals.
// Ownership changes only when the owner's chip selects are all idle, and every
// handover passes through a parked guard interval.
// Optional macro SPI_PAD_ARB_TIMEOUT_EN: force-release an idle owner while the
// other peripheral is waiting.
module spi_pad_arbiter #(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              clk_i,
  input logic              rst_ni,
  spi_pad_arbiter_if.slave bus
);

  localparam int unsigned MAX_CNT = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  if (GUARD_CYCLES < 1) begin : g_bad_guard
    $error("spi_pad_arbiter: GUARD_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_pad_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_owner;
  logic             r_last_owner;
  logic [1:0]       r_gnt;
  logic [CNT_W-1:0] r_guard_cnt;
  logic             r_busy;

  state_t           w_state_nxt;
  logic             w_owner_nxt;
  logic             w_last_owner_nxt;
  logic [1:0]       w_gnt_nxt;
  logic [CNT_W-1:0] w_guard_cnt_nxt;
  logic             w_release;
  logic             w_own_req;
  logic             w_own_csn_idle;

`ifdef SPI_PAD_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_nxt;
  logic             w_other_req;
`endif

  // Owner-side views used by the release decision
  assign w_own_req      = bus.req_i[r_owner];
  assign w_own_csn_idle = (bus.spi_csn_i[r_owner] == 4'hF);
`ifdef SPI_PAD_ARB_TIMEOUT_EN
  assign w_other_req    = bus.req_i[~r_owner];
`endif

  // State and bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_gnt        <= 2'b00;
      r_guard_cnt  <= '0;
      r_busy       <= 1'b0;
`ifdef SPI_PAD_ARB_TIMEOUT_EN
      r_idle_cnt   <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_gnt        <= w_gnt_nxt;
      r_guard_cnt  <= w_guard_cnt_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
`ifdef SPI_PAD_ARB_TIMEOUT_EN
      r_idle_cnt   <= w_idle_cnt_nxt;
`endif
    end
  end

  // Next-state: arbitration in IDLE, release detection in OWN, guard countdown
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_gnt_nxt        = r_gnt;
    w_guard_cnt_nxt  = r_guard_cnt;
    w_release        = 1'b0;
`ifdef SPI_PAD_ARB_TIMEOUT_EN
    w_idle_cnt_nxt   = r_idle_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (bus.req_i != 2'b00) begin
          // On a tie the peripheral that did not own the pads last wins
          w_owner_nxt = (bus.req_i == 2'b11) ? ~r_last_owner : bus.req_i[1];
          w_gnt_nxt   = w_owner_nxt ? 2'b10 : 2'b01;
          w_state_nxt = ST_OWN;
`ifdef SPI_PAD_ARB_TIMEOUT_EN
          w_idle_cnt_nxt = '0;
`endif
        end
      end

      ST_OWN: begin
        w_release = !w_own_req && w_own_csn_idle;
`ifdef SPI_PAD_ARB_TIMEOUT_EN
        // Idle owner with a waiting rival: count toward a forced release
        if (w_own_csn_idle && w_other_req) begin
          if (r_idle_cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_release = 1'b1;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
          end
        end else begin
          w_idle_cnt_nxt = '0;
        end
`endif
        if (w_release) begin
          w_gnt_nxt        = 2'b00;
          w_last_owner_nxt = r_owner;
          w_guard_cnt_nxt  = CNT_W'(GUARD_CYCLES);
          w_state_nxt      = ST_GUARD;
`ifdef SPI_PAD_ARB_TIMEOUT_EN
          w_idle_cnt_nxt   = '0;
`endif
        end
      end

      ST_GUARD: begin
        // Requests are deliberately not looked at until back in IDLE
        if (r_guard_cnt <= CNT_W'(1)) begin
          w_guard_cnt_nxt = '0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt - CNT_W'(1);
        end
      end

      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pad mux: zero-latency pass-through of the granted peripheral, parked otherwise
  always_comb begin
    bus.pad_clk_o = 1'b0;
    bus.pad_csn_o = 4'hF;
    bus.pad_oen_o = 4'hF;
    bus.pad_sdo_o = 4'h0;
    bus.spi_sdi_o = '0;
    if (r_gnt[0]) begin
      bus.pad_clk_o    = bus.spi_clk_i[0];
      bus.pad_csn_o    = bus.spi_csn_i[0];
      bus.pad_oen_o    = bus.spi_oen_i[0];
      bus.pad_sdo_o    = bus.spi_sdo_i[0];
      bus.spi_sdi_o[0] = bus.pad_sdi_i;
    end else if (r_gnt[1]) begin
      bus.pad_clk_o    = bus.spi_clk_i[1];
      bus.pad_csn_o    = bus.spi_csn_i[1];
      bus.pad_oen_o    = bus.spi_oen_i[1];
      bus.pad_sdo_o    = bus.spi_sdo_i[1];
      bus.spi_sdi_o[1] = bus.pad_sdi_i;
    end
  end

  assign bus.gnt_o  = r_gnt;
  assign bus.busy_o = r_busy;

endmodule

// File: tb/tb_spi_pad_arbiter.sv
// Self-checking bench for spi_pad_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-count based ownership model.
module tb_spi_pad_arbiter;

  localparam int GUARD = 4;
  localparam int TO    = 8;

  logic clk;
  logic rst_ni;
  spi_pad_arbiter_if bus ();

  spi_pad_arbiter #(
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Ownership model: owner index (-1 = parked), last owner, edge count and the
  // earliest edge at which a new grant may be issued.
  int m_owner    = -1;
  int m_last     = 1;
  int m_cyc      = 0;
  int m_next_arb = 0;
  int m_idle     = 0;
  bit m_valid    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every DUT output with what the model predicts for the current inputs
  task automatic check_outputs();
    logic [1:0] e_gnt;
    logic       e_clk;
    logic [3:0] e_csn, e_oen, e_sdo;
    logic [7:0] e_sdi;
    e_gnt = 2'b00; e_clk = 1'b0; e_csn = 4'hF; e_oen = 4'hF; e_sdo = 4'h0; e_sdi = 8'h00;
    if (m_owner == 0) begin
      e_gnt = 2'b01; e_clk = bus.spi_clk_i[0]; e_csn = bus.spi_csn_i[0];
      e_oen = bus.spi_oen_i[0]; e_sdo = bus.spi_sdo_i[0]; e_sdi = {4'h0, bus.pad_sdi_i};
    end else if (m_owner == 1) begin
      e_gnt = 2'b10; e_clk = bus.spi_clk_i[1]; e_csn = bus.spi_csn_i[1];
      e_oen = bus.spi_oen_i[1]; e_sdo = bus.spi_sdo_i[1]; e_sdi = {bus.pad_sdi_i, 4'h0};
    end
    check_eq("gnt",  32'(bus.gnt_o), 32'(e_gnt));
    check_eq("busy", 32'(bus.busy_o), 32'((m_owner >= 0) || (m_cyc < m_next_arb - 1)));
    check_eq("pad_clk", 32'(bus.pad_clk_o), 32'(e_clk));
    check_eq("pad_csn", 32'(bus.pad_csn_o), 32'(e_csn));
    check_eq("pad_oen", 32'(bus.pad_oen_o), 32'(e_oen));
    check_eq("pad_sdo", 32'(bus.pad_sdo_o), 32'(e_sdo));
    check_eq("spi_sdi", 32'(bus.spi_sdi_o), 32'(e_sdi));
  endtask

  // Advance the model across one rising edge with the given sampled inputs
  task automatic model_step(input logic rst_v, input logic [1:0] req_v,
                            input logic [3:0] csn0, input logic [3:0] csn1);
    logic [3:0] own_csn;
    bit         rel;
    m_cyc++;
    if (!rst_v) begin
      m_owner = -1; m_last = 1; m_idle = 0; m_next_arb = m_cyc + 1; m_valid = 1'b1;
    end else if (m_owner >= 0) begin
      own_csn = (m_owner == 1) ? csn1 : csn0;
      rel = !req_v[m_owner] && (own_csn == 4'hF);
`ifdef SPI_PAD_ARB_TIMEOUT_EN
      if ((own_csn == 4'hF) && req_v[1 - m_owner]) begin
        m_idle++;
        if (m_idle >= TO) rel = 1'b1;
      end else begin
        m_idle = 0;
      end
`endif
      if (rel) begin
        m_last = m_owner; m_owner = -1; m_idle = 0; m_next_arb = m_cyc + GUARD + 1;
      end
    end else if (m_cyc >= m_next_arb && req_v != 2'b00) begin
      if (req_v == 2'b11) m_owner = 1 - m_last;
      else                m_owner = req_v[0] ? 0 : 1;
      m_idle = 0;
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then model the next edge
  task automatic cycle(input logic rst_v, input logic [1:0] req_v,
                       input logic [3:0] csn0, input logic [3:0] csn1);
    @(negedge clk);
    rst_ni           = rst_v;
    bus.req_i        = req_v;
    bus.spi_csn_i[0] = csn0;
    bus.spi_csn_i[1] = csn1;
    bus.spi_clk_i    = 2'($urandom);
    bus.spi_oen_i    = 8'($urandom);
    bus.spi_sdo_i    = 8'($urandom);
    bus.pad_sdi_i    = 4'($urandom);
    #1;
    if (m_valid) check_outputs();
    model_step(rst_v, req_v, csn0, csn1);
  endtask

  initial begin
    int         n, m, last_k, k, fall_i, hold, rises;
    bit         fall_seen;
    logic [1:0] g, prev, req_v, rq;
    logic [3:0] c0, c1;

    rst_ni = 1'b0;
    bus.req_i = 2'b00; bus.spi_clk_i = '0; bus.spi_csn_i = '1;
    bus.spi_oen_i = '1; bus.spi_sdo_i = '0; bus.pad_sdi_i = '0;

    // Reset held with both requesting: pads parked, peripheral 0 wins first tie
    repeat (3) cycle(1'b0, 2'b11, 4'hF, 4'hF);
    cycle(1'b1, 2'b11, 4'hF, 4'hF);
    check_eq("rst_gnt", 32'(bus.gnt_o), 32'h0);
    check_eq("rst_csn", 32'(bus.pad_csn_o), 32'hF);
    check_eq("rst_busy", 32'(bus.busy_o), 32'h0);
    cycle(1'b1, 2'b01, 4'hE, 4'hF);
    check_eq("first_tie", 32'(bus.gnt_o), 32'h1);
    check_eq("pass_csn", 32'(bus.pad_csn_o), 32'hE);

    // Request dropped mid-transfer: grant held until all chip selects idle
    repeat (3) cycle(1'b1, 2'b00, 4'hE, 4'hF);
    check_eq("no_cut", 32'(bus.gnt_o), 32'h1);
    cycle(1'b1, 2'b00, 4'hF, 4'hF);
    cycle(1'b1, 2'b00, 4'hF, 4'hF);
    check_eq("release_gnt", 32'(bus.gnt_o), 32'h0);
    n = 0;
    while (bus.busy_o && n < 20) begin
      n++;
      cycle(1'b1, 2'b00, 4'hF, 4'hF);
    end
    check_eq("guard_len", 32'(n), 32'(GUARD));

    // Round-robin handover with both requesting continuously
    prev = bus.gnt_o; last_k = -1; fall_seen = 1'b0; fall_i = 0; hold = 0; rises = 0;
    for (int i = 0; i < 80; i++) begin
      req_v = (hold >= 3 && prev != 2'b00) ? (2'b11 & ~prev) : 2'b11;
      cycle(1'b1, req_v, 4'hF, 4'hF);
      g = bus.gnt_o;
      if (g != 2'b00 && prev == 2'b00) begin
        rises++;
        k = g[1] ? 1 : 0;
        if (fall_seen) check_eq("rr_gap", 32'(i - fall_i), 32'(GUARD + 1));
        if (last_k >= 0) check_eq("rr_alt", 32'(k), 32'(1 - last_k));
        last_k = k;
        hold = 0;
      end
      if (g == 2'b00 && prev != 2'b00) begin
        fall_i = i;
        fall_seen = 1'b1;
      end
      if (g != 2'b00) hold++;
      prev = g;
    end
    check_eq("rr_rises", 32'(rises >= 4), 32'h1);

    // Reset while peripheral 1 is mid-transfer
    cycle(1'b0, 2'b00, 4'hF, 4'hF);
    cycle(1'b1, 2'b10, 4'hF, 4'hD);
    cycle(1'b1, 2'b10, 4'hF, 4'hD);
    check_eq("own1", 32'(bus.gnt_o), 32'h2);
    cycle(1'b0, 2'b10, 4'hF, 4'hD);
    cycle(1'b1, 2'b00, 4'hF, 4'hF);
    check_eq("rst_mid_gnt", 32'(bus.gnt_o), 32'h0);
    check_eq("rst_mid_busy", 32'(bus.busy_o), 32'h0);
    check_eq("rst_mid_clk", 32'(bus.pad_clk_o), 32'h0);

    // Idle owner with a waiting rival
    cycle(1'b1, 2'b11, 4'hF, 4'hF);
    cycle(1'b1, 2'b11, 4'hF, 4'hF);
    n = 0;
    while (bus.gnt_o == 2'b01 && n < 40) begin
      n++;
      cycle(1'b1, 2'b11, 4'hF, 4'hF);
    end
`ifdef SPI_PAD_ARB_TIMEOUT_EN
    check_eq("timeout_len", 32'(n), 32'(TO));
    m = 0;
    while (bus.gnt_o == 2'b00 && m < 40) begin
      m++;
      cycle(1'b1, 2'b11, 4'hF, 4'hF);
    end
    check_eq("timeout_gap", 32'(m), 32'(GUARD + 1));
    check_eq("timeout_next", 32'(bus.gnt_o), 32'h2);
`else
    check_eq("no_timeout", 32'(n), 32'd40);
    check_eq("no_timeout_gnt", 32'(bus.gnt_o), 32'h1);
`endif

    // Randomized traffic with occasional resets
    rq = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rq[0] = ~rq[0];
      if ($urandom_range(0, 5) == 0) rq[1] = ~rq[1];
      c0 = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom);
      c1 = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom);
      cycle(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, rq, c0, c1);
    end
    cycle(1'b1, 2'b00, 4'hF, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_pad_arbiter.md
Name: spi_pad_arbiter

Overview:
- Shares the single set of SPI master pads (sdio0-3, csn0-1, sck) between two SPI master peripherals, for the N_SPI=2 configuration.
- Sits between the SPI master instances and the pad control block.
- Grants pad ownership by request/grant with round-robin fairness.
- Never cuts an active transfer; inserts a parked guard interval on every ownership change.

Parameters:
- GUARD_CYCLES, 4: parked cycles between release and the next grant; legal range >=1 (elaboration $error otherwise).
- TIMEOUT_CYCLES, 64: idle-hold limit, used only with the optional feature; >=1.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, active-low, synchronous
- req_i  in  2  per-peripheral pad request
- gnt_o  out  2  per-peripheral grant, registered, one-hot or zero
- spi_clk_i  in  [1:0]  peripheral sck
- spi_csn_i  in  [1:0][3:0]  peripheral chip selects, active-low
- spi_oen_i  in  [1:0][3:0]  peripheral data output-enable, active-low
- spi_sdo_i  in  [1:0][3:0]  peripheral data out
- spi_sdi_o  out  [1:0][3:0]  data in to peripherals
- pad_clk_o  out  1  to pad sck
- pad_csn_o  out  4  to pad csn (only [1:0] bonded)
- pad_oen_o  out  4  to pad sdio output-enable, active-low
- pad_sdo_o  out  4  to pad sdio data
- pad_sdi_i  in  4  from pad sdio
- busy_o  out  1  high when state != IDLE

Behaviour:
- Reset (rst_ni=0 sampled at a clk_i edge):
  - state=IDLE, gnt_o=2'b00, last_owner=1 (so peripheral 0 wins the first tie), counters=0.
  - Reset mid-transfer aborts immediately to the parked state.
- Parked pad values, driven whenever no grant is held: pad_clk_o=0, pad_csn_o=4'hF, pad_oen_o=4'hF, pad_sdo_o=4'h0. Both spi_sdi_o entries are 4'h0.
- Owned pads: when gnt_o[k]=1, the pad outputs are a combinational pass-through of peripheral k's signals, with zero latency.
  - spi_sdi_o[k]=pad_sdi_i; spi_sdi_o[other]=4'h0.
- FSM states: IDLE, OWN, GUARD.
  - IDLE:
    - If exactly one req_i bit is high, move to OWN for that requester.
    - If both are high, grant the one != last_owner.
    - gnt_o rises on the cycle after req_i is sampled, so grant latency is 1 clock.
  - OWN(k):
    - Release condition: req_i[k]=0 AND spi_csn_i[k]==4'hF.
    - When the release condition is met, gnt_o[k] falls next cycle, last_owner=k, the guard counter loads GUARD_CYCLES, and the FSM moves to GUARD.
    - If req_i[k] drops while any csn[k] bit is low, the grant is held until every csn is high. No mid-transfer cut.
  - GUARD:
    - Pads are parked; the counter decrements each cycle.
    - When the counter reaches 1, go to IDLE.
    - Total parked time from grant drop to IDLE is exactly GUARD_CYCLES cycles.
    - Requests are ignored during GUARD (arbitration happens in IDLE). The minimum gap between gnt_o[k] falling and gnt_o[j] rising is GUARD_CYCLES+1 cycles.
- Fairness: with both requesters continuously requesting and each releasing, grants alternate 0,1,0,1.
- Simultaneous events:
  - The owner re-requesting on the same cycle it would release does not release it (release needs req_i[k]=0).
  - A new request arriving on the release cycle is served after GUARD.
- Counter width is $clog2(max(GUARD_CYCLES,TIMEOUT_CYCLES)+1). The counter never wraps: it saturates at 0.
- The non-owner's sck, csn and sdo are ignored completely, including X values.

Optional Feature:
- Macro: SPI_PAD_ARB_TIMEOUT_EN.
- Enabled:
  - In OWN(k), an idle counter counts cycles where spi_csn_i[k]==4'hF and req_i[other]=1. Any csn low, or the other requester dropping, clears it.
  - On reaching TIMEOUT_CYCLES, ownership is force-released regardless of req_i[k]: gnt_o[k] falls, the FSM enters GUARD with last_owner=k, and the other requester is served next.
  - A forced release never occurs while any csn[k] bit is low.
- Disabled: the idle counter logic is absent; the owner holds the pads until it deasserts req_i.

Test Plan:
- Reset and parked pads: hold rst_ni=0 for 3 clocks with req_i=2'b11 -> gnt_o=00, pad_csn_o=F, pad_oen_o=F, pad_clk_o=0, busy_o=0. After release, gnt_o=01 one cycle later (peripheral 0 wins the first tie).
- Single owner pass-through: req_i=01 -> gnt_o=01 after 1 clock. Drive spi_sdo_i[0]=4'hA, spi_csn_i[0]=4'hE -> pad_sdo_o=A, pad_csn_o=E in the same cycle. Drive pad_sdi_i=5 -> spi_sdi_o[0]=5, spi_sdi_o[1]=0.
- No mid-transfer cut: owner 0 with csn[0]=4'hE, drop req_i[0] -> gnt_o stays 01. Raise csn[0] to F -> gnt_o=00 next cycle, then exactly GUARD_CYCLES=4 parked cycles, then IDLE.
- Round-robin handover: req_i=11 continuously, each owner toggling req low for 1 cycle with csn=F -> grant sequence 0,1,0,1. Each gap between gnt_o[k] falling and gnt_o[j] rising is 5 cycles.
- Reset mid-transfer: owner 1 active with csn[1]=4'hD, assert rst_ni=0 for 1 clock -> next cycle gnt_o=00, pads parked, state IDLE.
- Timeout (SPI_PAD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): owner 0 holds req with csn=F while req_i[1]=1 -> gnt_o[0] falls after 8 cycles, and gnt_o[1] rises 5 cycles later. Without the macro, gnt_o stays 01 indefinitely.
